// File: rtl/hdbe_op_pkg.sv
// Shared opcode encoding, result flags and opcode helpers for the
// HDBE integer operator units.
package hdbe_op_pkg;

  // Runtime opcode; encodings 9..15 are reserved and treated as illegal.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    SHL  = 4'd3,
    LSHR = 4'd4,
    ASHR = 4'd5,
    AND  = 4'd6,
    OR   = 4'd7,
    XOR  = 4'd8
  } op_e;

  localparam logic [3:0] OpLastLegal = 4'd8;

  // Status flags produced alongside every result.
  typedef struct packed {
    logic ovf;
    logic zero;
    logic illegal;
  } op_flags_t;

  // True when the raw opcode maps onto a member of op_e.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OpLastLegal);
  endfunction

endpackage

// File: rtl/binary_op_alu.sv
// Purely combinational two-operand integer operator. Results are truncated
// to ParamBitWidth; flags report signed overflow, zero result and illegal
// opcodes. Kept free of state so other multi-op units can reuse it.
module binary_op_alu
  import hdbe_op_pkg::*;
#(
  parameter int ParamBitWidth = 32
) (
  input  logic [3:0]               op,
  input  logic [ParamBitWidth-1:0] lhs,
  input  logic [ParamBitWidth-1:0] rhs,
  output logic [ParamBitWidth-1:0] result,
  output op_flags_t                flags
);

  localparam int W = ParamBitWidth;
  // Shift amounts are compared in at least 32 bits so the width constant
  // always fits, whatever the operand width.
  localparam int AmtW = (W > 32) ? W : 32;

  logic [W-1:0]        sum_s;
  logic [W-1:0]        diff_s;
  logic [2*W-1:0]      prod_s;
  logic [W-1:0]        shl_s;
  logic [W-1:0]        lshr_s;
  logic [W-1:0]        ashr_s;
  logic [AmtW-1:0]     amt_s;
  logic                amt_big_s;
  logic                sign_s;

  assign sum_s  = lhs + rhs;
  assign diff_s = lhs - rhs;
  // Operands are sign-extended to full width so the low 2W bits of the
  // product are the exact signed product.
  assign prod_s = $signed({{W{lhs[W-1]}}, lhs}) * $signed({{W{rhs[W-1]}}, rhs});

  assign amt_s     = AmtW'(rhs);
  assign amt_big_s = (amt_s >= AmtW'(W));
  assign sign_s    = lhs[W-1];
  assign shl_s     = lhs << rhs;
  assign lshr_s    = lhs >> rhs;
  assign ashr_s    = $signed(lhs) >>> rhs;

  // Select the operation result and its overflow flag.
  always_comb begin
    result        = '0;
    flags         = '0;
    case (op)
      ADD: begin
        result    = sum_s;
        flags.ovf = (lhs[W-1] == rhs[W-1]) && (sum_s[W-1] != lhs[W-1]);
      end
      SUB: begin
        result    = diff_s;
        flags.ovf = (lhs[W-1] != rhs[W-1]) && (diff_s[W-1] != lhs[W-1]);
      end
      MUL: begin
        result    = prod_s[W-1:0];
        flags.ovf = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
      end
      SHL:  result = amt_big_s ? '0 : shl_s;
      LSHR: result = amt_big_s ? '0 : lshr_s;
      ASHR: result = amt_big_s ? {W{sign_s}} : ashr_s;
      AND:  result = lhs & rhs;
      OR:   result = lhs | rhs;
      XOR:  result = lhs ^ rhs;
      default: begin
        result    = '0;
        flags.ovf = 1'b0;
      end
    endcase
    flags.illegal = !op_is_legal(op);
    flags.zero    = (result == '0);
  end

endmodule

// File: rtl/binary_op_pipe.sv
// Pipelined runtime-opcode integer operator with valid/ready handshake.
// The operation is evaluated before stage 0; later stages only retime.
// Every stage shifts when the output is empty or being consumed, so bubbles
// are kept and throughput is one transaction per cycle without backpressure.
module binary_op_pipe
  import hdbe_op_pkg::*;
#(
  parameter int ParamBitWidth = 32,
  parameter int ParamLatency  = 2,
  parameter int ParamTagWidth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [ParamBitWidth-1:0] in_lhs,
  input  logic [ParamBitWidth-1:0] in_rhs,
  input  logic [ParamTagWidth-1:0] in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ParamBitWidth-1:0] out_result,
  output logic [ParamTagWidth-1:0] out_tag,
  output logic                     out_ovf,
  output logic                     out_zero,
  output logic                     out_illegal
);

  localparam int W = ParamBitWidth;
  localparam int T = ParamTagWidth;

  logic [W-1:0] alu_result_s;
  op_flags_t    alu_flags_s;
  logic [W-1:0] load_result_s;
  logic [T-1:0] load_tag_s;
  op_flags_t    load_flags_s;

  binary_op_alu #(
    .ParamBitWidth(W)
  ) u_alu (
    .op     (in_op),
    .lhs    (in_lhs),
    .rhs    (in_rhs),
    .result (alu_result_s),
    .flags  (alu_flags_s)
  );

  // Bubbles carry all-zero data so outputs read 0 whenever out_valid is 0.
  always_comb begin
    if (in_valid) begin
      load_result_s = alu_result_s;
      load_tag_s    = in_tag;
      load_flags_s  = alu_flags_s;
    end else begin
      load_result_s = '0;
      load_tag_s    = '0;
      load_flags_s  = '0;
    end
  end

  generate
    if (ParamLatency == 0) begin : g_comb

      // Zero-latency path: outputs follow the inputs, forced idle in reset.
      always_comb begin
        if (reset) begin
          out_valid   = 1'b0;
          out_result  = '0;
          out_tag     = '0;
          out_ovf     = 1'b0;
          out_zero    = 1'b0;
          out_illegal = 1'b0;
          in_ready    = 1'b1;
        end else begin
          out_valid   = in_valid;
          out_result  = load_result_s;
          out_tag     = load_tag_s;
          out_ovf     = load_flags_s.ovf;
          out_zero    = load_flags_s.zero;
          out_illegal = load_flags_s.illegal;
          in_ready    = out_ready;
        end
      end

    end else begin : g_pipe

      localparam int Depth = ParamLatency;

      logic [Depth-1:0] valid_r;
      logic [W-1:0]     result_r [Depth];
      logic [T-1:0]     tag_r    [Depth];
      op_flags_t        flags_r  [Depth];
      logic             advance_s;

      assign advance_s = !valid_r[Depth-1] || out_ready;
      assign in_ready  = advance_s;

      // Shift the whole pipe on advance; reset discards everything in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_r <= '0;
          for (int i = 0; i < Depth; i++) begin
            result_r[i] <= '0;
            tag_r[i]    <= '0;
            flags_r[i]  <= '0;
          end
        end else if (advance_s) begin
          valid_r[0]  <= in_valid;
          result_r[0] <= load_result_s;
          tag_r[0]    <= load_tag_s;
          flags_r[0]  <= load_flags_s;
          for (int i = 1; i < Depth; i++) begin
            valid_r[i]  <= valid_r[i-1];
            result_r[i] <= result_r[i-1];
            tag_r[i]    <= tag_r[i-1];
            flags_r[i]  <= flags_r[i-1];
          end
        end
      end

      assign out_valid   = valid_r[Depth-1];
      assign out_result  = result_r[Depth-1];
      assign out_tag     = tag_r[Depth-1];
      assign out_ovf     = flags_r[Depth-1].ovf;
      assign out_zero    = flags_r[Depth-1].zero;
      assign out_illegal = flags_r[Depth-1].illegal;

    end
  endgenerate

endmodule

// File: tb/tb_binary_op_pipe.sv
// Self-checking bench: three instances (latency 0, 2, 4) share stimulus;
// the latency-2 instance is checked in detail against a behavioural model,
// all three are checked for reset behaviour.
module tb_binary_op_pipe;

  localparam int W = 8;
  localparam int T = 8;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] tag;
    logic       ovf;
    logic       zero;
    logic       ill;
  } item_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   in_op = 4'd0;
  logic [W-1:0] in_lhs = 8'd0;
  logic [W-1:0] in_rhs = 8'd0;
  logic [T-1:0] in_tag = 8'd0;

  logic         rdy0, vld0, ovf0, zero0, ill0;
  logic [W-1:0] res0;
  logic [T-1:0] tag0;
  logic         rdy2, vld2, ovf2, zero2, ill2;
  logic [W-1:0] res2;
  logic [T-1:0] tag2;
  logic         rdy4, vld4, ovf4, zero4, ill4;
  logic [W-1:0] res4;
  logic [T-1:0] tag4;

  int total = 0;
  int bad = 0;

  item_t exp_q[$];
  item_t got_q[$];
  logic  collect_en = 1'b0;

  binary_op_pipe #(.ParamBitWidth(W), .ParamLatency(0), .ParamTagWidth(T)) u_l0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_op(in_op),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag), .out_valid(vld0),
    .out_ready(out_ready), .out_result(res0), .out_tag(tag0), .out_ovf(ovf0),
    .out_zero(zero0), .out_illegal(ill0));

  binary_op_pipe #(.ParamBitWidth(W), .ParamLatency(2), .ParamTagWidth(T)) u_l2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag), .out_valid(vld2),
    .out_ready(out_ready), .out_result(res2), .out_tag(tag2), .out_ovf(ovf2),
    .out_zero(zero2), .out_illegal(ill2));

  binary_op_pipe #(.ParamBitWidth(W), .ParamLatency(4), .ParamTagWidth(T)) u_l4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag), .out_valid(vld4),
    .out_ready(out_ready), .out_result(res4), .out_tag(tag4), .out_ovf(ovf4),
    .out_zero(zero4), .out_illegal(ill4));

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: operands as signed/unsigned integers, range checks for overflow.
  function automatic item_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] tg);
    int    sa, sb, ua, ub, r;
    item_t it;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r = 0;
    it.tag = tg;
    it.ovf = 1'b0;
    it.ill = 1'b0;
    case (op)
      4'd0: begin r = sa + sb; it.ovf = (r > 127) || (r < -128); end
      4'd1: begin r = sa - sb; it.ovf = (r > 127) || (r < -128); end
      4'd2: begin r = sa * sb; it.ovf = (r > 127) || (r < -128); end
      4'd3: r = (ub >= 8) ? 0 : (ua << ub);
      4'd4: r = (ub >= 8) ? 0 : (ua >> ub);
      4'd5: r = sa >>> ((ub > 7) ? 7 : ub);
      4'd6: r = ua & ub;
      4'd7: r = ua | ub;
      4'd8: r = ua ^ ub;
      default: begin r = 0; it.ill = 1'b1; end
    endcase
    it.res  = r[7:0];
    it.zero = (it.res == 8'd0);
    return it;
  endfunction

  // Record accepted inputs (via the model) and consumed outputs of the latency-2 unit.
  always @(negedge clk) begin
    if (collect_en && !reset) begin
      if (in_valid && rdy2) exp_q.push_back(model(in_op, in_lhs, in_rhs, in_tag));
      if (vld2 && out_ready) got_q.push_back({res2, tag2, ovf2, zero2, ill2});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction, wait for its result; lat counts cycles after acceptance.
  task automatic run_one(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] tg, output item_t got, output int lat);
    int waited;
    in_op = op; in_lhs = a; in_rhs = b; in_tag = tg; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rdy2 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tick;
    in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (vld2) begin
        lat = c;
        got = {res2, tag2, ovf2, zero2, ill2};
        break;
      end
    end
    tick;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({vld0, vld2, vld4} !== 3'b000) begin
      bad++; $display("FAIL reset_valid: got %b want 000", {vld0, vld2, vld4});
    end
    total++;
    if ({res2, tag2, ovf2, zero2, ill2} !== 19'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {res2, tag2, ovf2, zero2, ill2});
    end
    total++;
    if ({rdy2, rdy4} !== 2'b11) begin
      bad++; $display("FAIL reset_ready: got %b want 11", {rdy2, rdy4});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy2, vld2} !== 2'b10) begin
      bad++; $display("FAIL post_reset: got rdy/vld %b want 10", {rdy2, vld2});
    end
  endtask

  task automatic test_directed;
    logic [3:0] d_op [10];
    logic [7:0] d_a [10];
    logic [7:0] d_b [10];
    logic [7:0] d_r [10];
    logic [2:0] d_f [10];
    item_t      got;
    int         lat;
    d_op = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd5, 4'd4, 4'd3, 4'd5, 4'hC, 4'd0};
    d_a  = '{8'h7F, 8'h05, 8'hF0, 8'h40, 8'h80, 8'h80, 8'h01, 8'h80, 8'h5A, 8'h03};
    d_b  = '{8'h01, 8'h05, 8'h03, 8'h04, 8'h03, 8'h03, 8'h09, 8'hC8, 8'hA5, 8'h04};
    d_r  = '{8'h80, 8'h00, 8'hD0, 8'h00, 8'hF0, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h07};
    d_f  = '{3'b100, 3'b010, 3'b000, 3'b110, 3'b000, 3'b000, 3'b010, 3'b000, 3'b011, 3'b000};
    tick;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_one(d_op[i], d_a[i], d_b[i], 8'h10 + 8'(i), got, lat);
      total++;
      if (got !== {d_r[i], 8'h10 + 8'(i), d_f[i]}) begin
        bad++;
        $display("FAIL directed_%0d: got res=%h tag=%h ovf/zero/ill=%b want res=%h tag=%h ovf/zero/ill=%b",
                 i, got.res, got.tag, {got.ovf, got.zero, got.ill}, d_r[i], 8'h10 + 8'(i), d_f[i]);
      end
      total++;
      if (lat !== 2) begin
        bad++; $display("FAIL latency_%0d: got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_random;
    logic        was_stall;
    logic [19:0] snap;
    int          n;
    exp_q.delete();
    got_q.delete();
    was_stall = 1'b0;
    snap = '0;
    tick;
    collect_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_op     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      in_lhs    = 8'($urandom);
      in_rhs    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      in_tag    = 8'(c);
      @(negedge clk);
      if (was_stall) begin
        total++;
        if ({vld2, res2, tag2, ovf2, zero2, ill2} !== snap) begin
          bad++; $display("FAIL stall_hold_%0d: got %h want %h", c,
                          {vld2, res2, tag2, ovf2, zero2, ill2}, snap);
        end
      end
      was_stall = vld2 && !out_ready;
      snap = {vld2, res2, tag2, ovf2, zero2, ill2};
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick;
    collect_en = 1'b0;
    total++;
    if (got_q.size() !== exp_q.size() || exp_q.size() < 50) begin
      bad++; $display("FAIL random_count: got %0d results want %0d (>=50)", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL random_item_%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          sent;
    logic [19:0] snap;
    logic        exp_rdy;
    exp_q.delete();
    got_q.delete();
    sent = 0;
    snap = '0;
    tick;
    collect_en = 1'b1;
    in_op = 4'($urandom_range(0, 8)); in_lhs = 8'($urandom); in_rhs = 8'($urandom_range(0, 9));
    for (int k = 0; k < 16; k++) begin
      out_ready = !(k >= 4 && k <= 7);
      in_valid  = (sent < 6);
      in_tag    = 8'(sent + 1);
      @(negedge clk);
      if (k <= 9) begin
        exp_rdy = (k < 4) || (k > 7);
        total++;
        if (rdy2 !== exp_rdy) begin
          bad++; $display("FAIL bp_in_ready_c%0d: got %b want %b", k, rdy2, exp_rdy);
        end
      end
      if (k == 4) snap = {vld2, res2, tag2, ovf2, zero2, ill2};
      if (k >= 5 && k <= 7) begin
        total++;
        if ({vld2, res2, tag2, ovf2, zero2, ill2} !== snap || vld2 !== 1'b1) begin
          bad++; $display("FAIL bp_stable_c%0d: got %h want %h (valid)", k,
                          {vld2, res2, tag2, ovf2, zero2, ill2}, snap);
        end
      end
      if (in_valid && rdy2) begin
        sent++;
        tick;
        in_op = 4'($urandom_range(0, 8)); in_lhs = 8'($urandom); in_rhs = 8'($urandom_range(0, 9));
      end else begin
        tick;
      end
    end
    in_valid = 1'b0;
    collect_en = 1'b0;
    total++;
    if (got_q.size() !== 6 || sent !== 6) begin
      bad++; $display("FAIL bp_count: got %0d results %0d sent want 6", got_q.size(), sent);
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      total++;
      if (got_q[i].tag !== 8'(i + 1) || i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_order_%0d: got %h want tag %0d", i, got_q[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_op = 4'($urandom_range(0, 8)); in_lhs = 8'($urandom); in_rhs = 8'($urandom);
      in_tag = 8'h40 + 8'(k);
      tick;
    end
    @(negedge clk);
    total++;
    if ({vld0, vld2, vld4, rdy2, rdy4} !== 5'b11100) begin
      bad++; $display("FAIL pre_reset_stall: got vld/rdy %b want 11100", {vld0, vld2, vld4, rdy2, rdy4});
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({vld0, vld2, vld4} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_valid: got %b want 000", {vld0, vld2, vld4});
    end
    total++;
    if ({res0, tag0, ovf0, zero0, ill0, res2, tag2, ovf2, zero2, ill2,
         res4, tag4, ovf4, zero4, ill4} !== 57'd0) begin
      bad++; $display("FAIL mid_reset_data: got %h %h %h want 0", {res0, tag0, ovf0, zero0, ill0},
                      {res2, tag2, ovf2, zero2, ill2}, {res4, tag4, ovf4, zero4, ill4});
    end
    total++;
    if ({rdy0, rdy2, rdy4} !== 3'b111) begin
      bad++; $display("FAIL mid_reset_ready: got %b want 111", {rdy0, rdy2, rdy4});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if ({vld0, vld2, vld4, rdy2, rdy4} !== 5'b00011 || {res2, res4} !== 16'd0) begin
        bad++; $display("FAIL post_reset_stale_%0d: got vld/rdy %b res %h want 00011 0", k,
                        {vld0, vld2, vld4, rdy2, rdy4}, {res2, res4});
      end
    end
  endtask

  // Test sequence.
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
